// File: rtl/picosoc_bus_fabric_pkg.sv
// Shared types and constants for the PicoRV32 bus fabric.
package picosoc_bus_pkg;

  localparam int unsigned MAX_SLAVES = 16;

  localparam int unsigned ERR_UNMAPPED = 0;
  localparam int unsigned ERR_TIMEOUT  = 1;

  localparam logic [31:0] ERR_RDATA_DFLT = 32'hBADB_AD00;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR
  } bus_state_t;

  // Pull the 32-bit entry for slave idx out of a flattened address table.
  function automatic logic [31:0] slv_field(input logic [32*MAX_SLAVES-1:0] vec,
                                            input int unsigned idx);
    return vec[32*idx +: 32];
  endfunction

endpackage

// File: rtl/picosoc_bus_fabric_if.sv
// PicoRV32 native bus on the CPU side plus the fanned-out slave signals.
// master: the CPU driving requests; slave: the fabric answering them and
// forwarding to the memory-mapped slaves.
interface picosoc_bus_fabric_if #(
  parameter int unsigned N_SLAVES = 4
) ();

  logic                  m_valid;
  logic                  m_instr;
  logic                  m_ready;
  logic [31:0]           m_addr;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic [31:0]           m_rdata;

  logic [N_SLAVES-1:0]   s_valid;
  logic [N_SLAVES-1:0]   s_ready;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic [32*N_SLAVES-1:0] s_rdata;

  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

endinterface

// File: rtl/picosoc_bus_fabric_addr_decode.sv
// Table-driven priority address decoder: lowest matching slave index wins.
module picosoc_addr_decode
  import picosoc_bus_pkg::*;
#(
  parameter int unsigned          N_SLAVES = 4,
  parameter logic [32*N_SLAVES-1:0] SLV_BASE = '0,
  parameter logic [32*N_SLAVES-1:0] SLV_MASK = '0
) (
  input  logic [31:0]         addr,
  output logic [N_SLAVES-1:0] hit,
  output logic                miss
);

  localparam int unsigned TBL_W = 32 * MAX_SLAVES;
  localparam logic [TBL_W-1:0] BASE_TBL = TBL_W'(SLV_BASE);
  localparam logic [TBL_W-1:0] MASK_TBL = TBL_W'(SLV_MASK);

  // Scan upward and stop at the first match so overlaps resolve to the lowest index.
  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (miss && ((addr & slv_field(MASK_TBL, i)) == slv_field(BASE_TBL, i))) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// Interconnect between the PicoRV32 native bus and N slaves with registered
// slave selection, a per-transfer timeout and sticky bus-error reporting.
module picosoc_bus_fabric
  import picosoc_bus_pkg::*;
#(
  parameter int unsigned            N_SLAVES  = 4,
  parameter logic [32*N_SLAVES-1:0] SLV_BASE  = '0,
  parameter logic [32*N_SLAVES-1:0] SLV_MASK  = '0,
  parameter int unsigned            TIMEOUT   = 255,
  parameter logic [31:0]            ERR_RDATA = ERR_RDATA_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  picosoc_bus_fabric_if.slave  bus,
  input  logic                 err_clr,
  output logic                 err_irq,
  output logic [1:0]           err_status,
  output logic [31:0]          err_addr
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  bus_state_t          state;
  logic [N_SLAVES-1:0] sel_q;
  logic [N_SLAVES-1:0] hit;
  logic                miss;
  logic [CNT_W-1:0]    cnt;
  logic                sel_ready;
  logic                timeout_hit;
  logic [1:0]          err_set;
  logic [31:0]         rdata_sel;
  logic                unused_instr;

  picosoc_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (bus.m_addr),
    .hit  (hit),
    .miss (miss)
  );

  assign unused_instr = bus.m_instr;

  assign bus.s_addr  = bus.m_addr;
  assign bus.s_wdata = bus.m_wdata;
  assign bus.s_wstrb = bus.m_wstrb;

  assign sel_ready   = |(bus.s_ready & sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Error events recorded on the edge that moves the FSM into ERR.
  always_comb begin
    err_set               = '0;
    err_set[ERR_UNMAPPED] = (state == IDLE) && bus.m_valid && miss;
    err_set[ERR_TIMEOUT]  = (state == ACCESS) && bus.m_valid && !sel_ready && timeout_hit;
  end

  // Read-data mux driven by the latched one-hot selection.
  always_comb begin
    rdata_sel = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | bus.s_rdata[32*i +: 32];
    end
  end

  // Master/slave handshake outputs, forced quiet while reset is asserted.
  always_comb begin
    bus.s_valid = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    if (!reset) begin
      case (state)
        ACCESS: begin
          bus.s_valid = sel_q;
          bus.m_ready = bus.m_valid && sel_ready;
          bus.m_rdata = rdata_sel;
        end
        ERR: begin
          bus.m_ready = 1'b1;
          bus.m_rdata = ERR_RDATA;
        end
        default: ;
      endcase
    end
  end

  // Transfer FSM, timeout counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_q      <= '0;
      cnt        <= '0;
      err_irq    <= 1'b0;
      err_status <= '0;
      err_addr   <= '0;
    end else begin
      err_irq <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.m_valid) begin
            if (miss) begin
              state   <= ERR;
              err_irq <= 1'b1;
            end else begin
              sel_q <= hit;
              cnt   <= '0;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!bus.m_valid || sel_ready) begin
            state <= IDLE;
            sel_q <= '0;
          end else if (timeout_hit) begin
            state   <= ERR;
            sel_q   <= '0;
            err_irq <= 1'b1;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // A clear in the same cycle as a new error yields the new error alone.
      if (|err_set) begin
        err_status <= (err_clr ? 2'b00 : err_status) | err_set;
        if (err_clr || (err_status == 2'b00)) err_addr <= bus.m_addr;
      end else if (err_clr) begin
        err_status <= '0;
        err_addr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Directed bench for picosoc_bus_fabric: four behavioural slaves with
// programmable ready delay and a word memory each.
module tb_picosoc_bus_fabric;

  localparam logic [127:0] BASES = {32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0300_0000};
  localparam logic [127:0] MASKS = {32'hFFFF_F000, 32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_0000};
  localparam logic [31:0]  BAD   = 32'hBADB_AD00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_irq;
  logic [1:0]  err_status;
  logic [31:0] err_addr;
  logic        mem_init = 1'b1;

  logic [31:0] smem    [4][16];
  logic [31:0] ref_mem [4][16];
  logic [7:0]  dly  [4];
  logic [7:0]  wcnt [4];

  int n_cmp = 0;
  int n_err = 0;
  int spurious = 0;

  always #5 clk = ~clk;

  picosoc_bus_fabric_if #(.N_SLAVES(4)) bus ();

  picosoc_bus_fabric #(
    .N_SLAVES  (4),
    .SLV_BASE  (BASES),
    .SLV_MASK  (MASKS),
    .TIMEOUT   (8),
    .ERR_RDATA (BAD)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .err_clr    (err_clr),
    .err_irq    (err_irq),
    .err_status (err_status),
    .err_addr   (err_addr)
  );

  function automatic logic [31:0] pat(input int i, input int j);
    return 32'hA000_0000 + 32'(i * 256 + j);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] base_of(input int s);
    case (s)
      0:       return 32'h0300_0000;
      1:       return 32'h0200_0000;
      2:       return 32'h0310_0000;
      default: return 32'h0400_0000;
    endcase
  endfunction

  // Slave ready after dly valid cycles; read data straight from memory.
  always_comb begin
    bus.s_ready = '0;
    bus.s_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      bus.s_ready[i]          = bus.s_valid[i] && (wcnt[i] == dly[i]);
      bus.s_rdata[32*i +: 32] = smem[i][bus.s_addr[5:2]];
    end
  end

  // Slave wait counters and byte-enabled memory writes.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_init) begin
        for (int j = 0; j < 16; j++) smem[i][j] <= pat(i, j);
      end else if (bus.s_valid[i] && bus.s_ready[i] && (|bus.s_wstrb)) begin
        smem[i][bus.s_addr[5:2]] <= merge(smem[i][bus.s_addr[5:2]], bus.s_wdata, bus.s_wstrb);
      end
      wcnt[i] <= (bus.s_valid[i] && !bus.s_ready[i]) ? wcnt[i] + 8'd1 : 8'd0;
    end
  end

  // Ready with no request outstanding is a protocol violation.
  always @(negedge clk) begin
    if (bus.m_ready && !bus.m_valid) spurious++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One native-protocol transfer; returns data, latency, s_valid activity and irq cycles.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int lat, output logic [3:0] svs,
                      output int svc, output int irqs);
    bit done;
    @(posedge clk); #1;
    bus.m_valid = 1'b1;
    bus.m_addr  = a;
    bus.m_wdata = wd;
    bus.m_wstrb = ws;
    rd = '0; lat = 0; svs = '0; svc = 0; irqs = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (|bus.s_valid) begin
        svc++;
        svs = svs | bus.s_valid;
      end
      if (err_irq) irqs++;
      if (bus.m_ready) begin
        rd   = bus.m_rdata;
        done = 1'b1;
        break;
      end
      lat++;
    end
    if (!done) chk("xfer_bound", 32'(done), 32'd1);
    @(posedge clk); #1;
    bus.m_valid = 1'b0;
    bus.m_wstrb = '0;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic [3:0]  svs, ws;
    int          lat, svc, irqs, s, idx, d;

    bus.m_valid = 1'b0;
    bus.m_instr = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    for (int i = 0; i < 4; i++) begin
      dly[i] = 8'd0;
      for (int j = 0; j < 16; j++) ref_mem[i][j] = pat(i, j);
    end

    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
    chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_m_rdata", bus.m_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_status", 32'(err_status), 32'd0);
    chk("rst_addr",   err_addr,        32'd0);
    chk("rst_irq",    32'(err_irq),    32'd0);

    // Slave 1, ready on first valid cycle
    dly[1] = 8'd0;
    xfer(32'h0200_0004, 32'h1234_5678, 4'hF, rd, lat, svs, svc, irqs);
    ref_mem[1][1] = 32'h1234_5678;
    chk("wr1_lat", 32'(lat), 32'd1);
    chk("wr1_sel", 32'(svs), 32'h2);
    xfer(32'h0200_0004, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("rd1_data", rd, 32'h1234_5678);
    chk("rd1_lat",  32'(lat), 32'd1);
    chk("rd1_sel",  32'(svs), 32'h2);
    chk("rd1_svc",  32'(svc), 32'd1);
    chk("rd1_stat", 32'(err_status), 32'd0);

    // Unmapped read
    xfer(32'h0500_0000, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("um_data", rd, BAD);
    chk("um_lat",  32'(lat), 32'd1);
    chk("um_irq",  32'(irqs), 32'd1);
    chk("um_svc",  32'(svc), 32'd0);
    chk("um_stat", 32'(err_status), 32'h1);
    chk("um_addr", err_addr, 32'h0500_0000);
    clr_pulse();
    chk("clr1_stat", 32'(err_status), 32'd0);

    // Timeout on slave 3, then a second error keeps the first address
    dly[3] = 8'd255;
    xfer(32'h0400_0010, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("to_data", rd, BAD);
    chk("to_lat",  32'(lat), 32'd9);
    chk("to_svc",  32'(svc), 32'd8);
    chk("to_sel",  32'(svs), 32'h8);
    chk("to_irq",  32'(irqs), 32'd1);
    chk("to_stat", 32'(err_status), 32'h2);
    chk("to_addr", err_addr, 32'h0400_0010);
    xfer(32'h0600_0000, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("err2_stat", 32'(err_status), 32'h3);
    chk("err2_addr", err_addr, 32'h0400_0010);

    // Clear coinciding with a new unmapped error: the new error wins
    @(posedge clk); #1;
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0700_0000;
    err_clr     = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clrnew_rdy", 32'(bus.m_ready), 32'd1);
    @(posedge clk); #1 bus.m_valid = 1'b0;
    chk("clrnew_stat", 32'(err_status), 32'h1);
    chk("clrnew_addr", err_addr, 32'h0700_0000);
    clr_pulse();
    chk("clr2_stat", 32'(err_status), 32'd0);
    chk("clr2_addr", err_addr, 32'd0);

    // Ready in the last cycle before timeout completes normally
    dly[3] = 8'd7;
    xfer(32'h0400_0020, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("late_data", rd, ref_mem[3][8]);
    chk("late_lat",  32'(lat), 32'd8);
    chk("late_irq",  32'(irqs), 32'd0);
    chk("late_stat", 32'(err_status), 32'd0);

    // Overlapping slaves 0 and 2
    dly[0] = 8'd0;
    xfer(32'h0300_0010, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("ovl_sel",  32'(svs), 32'h1);
    chk("ovl_data", rd, ref_mem[0][4]);

    // Reset in the third ACCESS cycle of a write
    xfer(32'h0500_0000, 32'h0, 4'h0, rd, lat, svs, svc, irqs);
    chk("pre_rst_stat", 32'(err_status), 32'h1);
    dly[3] = 8'd255;
    @(posedge clk); #1;
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0400_0000;
    bus.m_wdata = 32'hDEAD_BEEF;
    bus.m_wstrb = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_s_valid", 32'(bus.s_valid), 32'h8);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_s_valid", 32'(bus.s_valid), 32'd0);
    chk("mr_m_ready", 32'(bus.m_ready), 32'd0);
    chk("mr_m_rdata", bus.m_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_wstrb = '0;
    @(negedge clk);
    chk("ar_s_valid", 32'(bus.s_valid), 32'd0);
    chk("ar_m_ready", 32'(bus.m_ready), 32'd0);
    chk("ar_stat",    32'(err_status), 32'd0);
    chk("ar_addr",    err_addr, 32'd0);
    chk("ar_irq",     32'(err_irq), 32'd0);
    chk("ar_nowrite", smem[3][0], ref_mem[3][0]);

    // Random back-to-back traffic
    for (int n = 0; n < 100; n++) begin
      s   = int'($urandom_range(3, 0));
      idx = int'($urandom_range(15, 0));
      d   = int'($urandom_range(5, 0));
      dly[s] = 8'(d);
      a  = base_of(s) | (32'(idx) << 2);
      wd = $urandom;
      ws = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
      xfer(a, wd, ws, rd, lat, svs, svc, irqs);
      chk("rnd_lat", 32'(lat), 32'(d + 1));
      chk("rnd_sel", 32'(svs), 32'(1 << s));
      if (ws == 4'h0) chk("rnd_rdata", rd, ref_mem[s][idx]);
      else ref_mem[s][idx] = merge(ref_mem[s][idx], wd, ws);
    end

    // Read back every word
    for (int i = 0; i < 4; i++) dly[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) begin
        xfer(base_of(i) | (32'(j) << 2), 32'h0, 4'h0, rd, lat, svs, svc, irqs);
        chk("sweep_data", rd, ref_mem[i][j]);
      end
    end

    chk("spurious_rdy", 32'(spurious), 32'd0);
    chk("end_stat", 32'(err_status), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
